// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state enums and frame constants
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_responder_if.sv
// rtl/uart_responder_if.sv - CPU-side UART strobe bus (rdn/wrn/data/status)
interface uart_responder_if;

  logic        rdn;
  logic        wrn;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe;
  logic        data_ready;
  logic        tbre;
  logic        tsre;

  modport master (
    output rdn, wrn, data_in,
    input  data_out, data_oe, data_ready, tbre, tsre
  );

  modport slave (
    input  rdn, wrn, data_in,
    output data_out, data_oe, data_ready, tbre, tsre
  );

endinterface

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - RX synchroniser, 8N1 deserialiser, RBR and error flags
// UART_LOOPBACK_EN selects txd (loop_in) instead of the rxd pin as the serial source.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rxd,
  input  logic       loop_in,
  input  logic       rd_release,
  output logic [7:0] rbr,
  output logic       data_ready,
  output logic       rx_overrun,
  output logic       framing_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t      state, state_next;
  logic           line_in, sync1, rx_s, rx_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     idx;
  logic [7:0]     shreg;
  logic           bit_end, byte_done, frame_bad, unused_in;

`ifdef UART_LOOPBACK_EN
  assign line_in   = loop_in;
  assign unused_in = rxd;
`else
  assign line_in   = rxd;
  assign unused_in = loop_in;
`endif

  always_comb begin
    state_next = state;
    bit_end    = (cnt == BIT_LAST);
    byte_done  = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_s) state_next = RX_START;
      // Mid-start-bit check rejects short low glitches
      RX_START: if (cnt == HALF_LAST) state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && idx == 3'(DATA_BITS - 1)) state_next = RX_STOP;
      RX_STOP: begin
        if (bit_end) begin
          state_next = RX_IDLE;
          byte_done  = rx_s;
          frame_bad  = !rx_s;
        end
      end
      default:  state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= RX_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      rbr         <= '0;
      data_ready  <= 1'b0;
      rx_overrun  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      sync1   <= line_in;
      rx_s    <= sync1;
      rx_prev <= rx_s;

      if (state == RX_IDLE || state_next != state || bit_end) cnt <= '0;
      else                                                    cnt <= cnt + 1'b1;

      if (state == RX_START) idx <= '0;
      else if (state == RX_DATA && bit_end) begin
        idx   <= idx + 1'b1;
        shreg <= {rx_s, shreg[7:1]};
      end

      // A completing byte beats a simultaneous read release
      if (byte_done) begin
        rbr        <= shreg;
        data_ready <= 1'b1;
        if (data_ready) rx_overrun <= 1'b1;
      end else if (rd_release) begin
        data_ready <= 1'b0;
      end

      if (frame_bad) framing_err <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_responder.sv
// rtl/uart_responder.sv - CPU UART device: strobe decode, THR/TX serialiser, bus read
// UART_LOOPBACK_EN (in uart_rx_deser) feeds txd back into the receiver.
module uart_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             CLK,
  input  logic             RST,
  uart_responder_if.slave  bus,
  input  logic             rxd,
  output logic             txd,
  output logic             tx_overrun,
  output logic             rx_overrun,
  output logic             framing_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     tx_state, tx_next;
  logic          rdn_q, wrn_q, wr_accept, rd_release;
  logic [7:0]    thr, tsr, rbr;
  logic          tbre, tsre, tx_load, tx_bit_end;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [15:0]   data_out_q;
  logic          unused_hi;

  assign unused_hi     = ^bus.data_in[15:8];
  assign bus.data_out  = data_out_q;
  assign bus.data_oe   = ~rdn_q;
  assign bus.tbre      = tbre;
  assign bus.tsre      = tsre;

  always_comb begin
    wr_accept  = ~bus.wrn & wrn_q;
    rd_release = bus.rdn & ~rdn_q;
    tx_bit_end = (tx_cnt == BIT_LAST);
    tx_next    = tx_state;
    tx_load    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tbre) begin
          tx_load = 1'b1;
          tx_next = TX_START;
        end
      end
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_idx == 3'(DATA_BITS - 1)) tx_next = TX_STOP;
      TX_STOP: begin
        // Pending THR chains straight into the next start bit
        if (tx_bit_end) begin
          if (!tbre) begin
            tx_load = 1'b1;
            tx_next = TX_START;
          end else begin
            tx_next = TX_IDLE;
          end
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      data_out_q <= '0;
      thr        <= '0;
      tsr        <= '0;
      tbre       <= 1'b1;
      tsre       <= 1'b1;
      txd        <= 1'b1;
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_overrun <= 1'b0;
    end else begin
      rdn_q      <= bus.rdn;
      wrn_q      <= bus.wrn;
      data_out_q <= {8'h00, rbr};

      // THR is freed by the transfer before a same-cycle write lands in it
      if (tx_load) begin
        tsr <= thr;
        if (wr_accept) thr  <= bus.data_in[7:0];
        else           tbre <= 1'b1;
      end else if (wr_accept) begin
        if (tbre) begin
          thr  <= bus.data_in[7:0];
          tbre <= 1'b0;
        end else begin
          tx_overrun <= 1'b1;
        end
      end

      if (tx_load || tx_bit_end) tx_cnt <= '0;
      else if (tx_state != TX_IDLE) tx_cnt <= tx_cnt + 1'b1;

      if (tx_load) begin
        txd  <= 1'b0;
        tsre <= 1'b0;
      end else if (tx_bit_end) begin
        case (tx_state)
          TX_START: begin
            txd    <= tsr[0];
            tx_idx <= '0;
          end
          TX_DATA: begin
            tx_idx <= tx_idx + 1'b1;
            if (tx_idx == 3'(DATA_BITS - 1)) begin
              txd <= 1'b1;
            end else begin
              txd <= tsr[1];
              tsr <= {1'b0, tsr[7:1]};
            end
          end
          TX_STOP: tsre <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK         (CLK),
    .RST         (RST),
    .rxd         (rxd),
    .loop_in     (txd),
    .rd_release  (rd_release),
    .rbr         (rbr),
    .data_ready  (bus.data_ready),
    .rx_overrun  (rx_overrun),
    .framing_err (framing_err)
  );

endmodule
